// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write ports, read ports, scoreboard allocate and status.
// Traffic contract: there is no backpressure. Once ready=1 every port is sampled
// each cycle. While ready=0 the block ignores we/re/alloc_en and returns zeros.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
);
    logic [NWR-1:0]        we;
    logic [NWR*ADDR_W-1:0] waddr;
    logic [NWR*DATA_W-1:0] wdata;
    logic [NRD-1:0]        re;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rbusy;
    logic                  alloc_en;
    logic [ADDR_W-1:0]     alloc_addr;
    logic                  ready;
    logic                  fsm_state;  // 0 = INIT, 1 = RUN

    modport master (
        output we, waddr, wdata, re, raddr, alloc_en, alloc_addr,
        input  rdata, rbusy, ready, fsm_state
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, alloc_en, alloc_addr,
        output rdata, rbusy, ready, fsm_state
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and a per-register busy scoreboard.
// After reset an INIT walk clears every register before the block reports ready.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt;
    logic               ready_q;
    logic [DATA_W-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]   busy, busy_d;
    logic               run;

    logic [ADDR_W-1:0]  wa [NWR];
    logic [DATA_W-1:0]  wd [NWR];
    logic [NWR-1:0]     wr_ok;
    logic [ADDR_W-1:0]  ra [NRD];
    logic [DATA_W-1:0]  rd [NRD];
    logic [NRD-1:0]     rb;
    logic [NRD-1:0]     byp;

    // Reset also masks the read path combinationally, not just from the next edge.
    assign run = (state_q == RUN) && !rst;

    always_comb begin
        for (int i = 0; i < NWR; i++) begin
            wa[i]    = bus.waddr[i*ADDR_W +: ADDR_W];
            wd[i]    = bus.wdata[i*DATA_W +: DATA_W];
            wr_ok[i] = run && bus.we[i] && (wa[i] != '0);
        end
    end

    // Higher-numbered write ports are visited last, so port 1 wins on a collision.
    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            ra[j]  = bus.raddr[j*ADDR_W +: ADDR_W];
            rd[j]  = '0;
            byp[j] = 1'b0;
            rb[j]  = 1'b0;
            if (run && bus.re[j] && (ra[j] != '0)) begin
                rd[j] = regs[ra[j]];
                for (int i = 0; i < NWR; i++) begin
                    if (wr_ok[i] && (wa[i] == ra[j])) begin
                        rd[j]  = wd[i];
                        byp[j] = 1'b1;
                    end
                end
                rb[j] = busy[ra[j]] && !byp[j];
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        bus.rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            bus.rdata[j*DATA_W +: DATA_W] = rd[j];
            bus.rbusy[j]                  = rb[j];
        end
    end

    // Writes clear first, then an allocate on the same register sets it again.
    always_comb begin
        busy_d = busy;
        for (int i = 0; i < NWR; i++) begin
            if (wr_ok[i]) busy_d[wa[i]] = 1'b0;
        end
        if (run && bus.alloc_en && (bus.alloc_addr != '0)) busy_d[bus.alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (cnt == LAST) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt     <= '0;
            ready_q <= 1'b0;
            busy    <= '0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            if (state_q == INIT) begin
                if (cnt == LAST) ready_q <= 1'b1;
                else             cnt     <= cnt + 1'b1;
            end
        end
    end

    // Storage is not reset; the INIT walk clears it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                regs[cnt] <= '0;
            end else begin
                for (int i = 0; i < NWR; i++) begin
                    if (wr_ok[i]) regs[wa[i]] <= wd[i];
                end
            end
        end
    end

    assign bus.ready     = ready_q;
    assign bus.fsm_state = state_q;

    a_busy0_clear: assert property (@(posedge clk) disable iff (rst) busy[0] == 1'b0);
    a_ready_state: assert property (@(posedge clk) disable iff (rst) ready_q == (state_q == RUN));
endmodule
